// File: rtl/mnist_downscaler.sv
// Crops a square ROI from an RGB raster, box-averages it to a D_DIM x D_DIM luma image and
// double-buffers the result. Optional build macro: DOWNSCALER_INVERT_EN stores 255 - average.
module mnist_downscaler #(
    parameter int H_RES       = 1920,
    parameter int V_RES       = 1080,
    parameter int D_DIM       = 28,
    parameter int BLK_LOG2    = 5,
    parameter int ROI_H_START = 512,
    parameter int ROI_V_START = 92
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_valid_i,
    input  logic [23:0] data_i,
    input  logic [9:0]  rd_addr_i,
    output logic [7:0]  rd_data_o,
    output logic        frame_done_o,
    output logic        rd_bank_o
);

    localparam int ROI_EDGE = D_DIM << BLK_LOG2;
    localparam int ACC_W    = 2 * BLK_LOG2 + 8;
    localparam int N_PIX    = D_DIM * D_DIM;

    localparam logic [10:0] H_LO   = 11'(ROI_H_START);
    localparam logic [10:0] H_HI   = 11'(ROI_H_START + ROI_EDGE);
    localparam logic [10:0] V_LO   = 11'(ROI_V_START);
    localparam logic [10:0] V_HI   = 11'(ROI_V_START + ROI_EDGE);
    localparam logic [10:0] H_LAST = 11'(H_RES - 1);
    localparam logic [10:0] V_LAST = 11'(V_RES - 1);
    localparam logic [9:0]  ADDR_LAST = 10'(N_PIX - 1);
    localparam logic [9:0]  ADDR_END  = 10'(N_PIX);

    logic [10:0] h_q, h_d, v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (data_valid_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    // Stage 1: luma plus a block tag, so stage 2 never looks at the raster counters.
    logic [10:0]         h_off, v_off;
    logic [9:0]          luma_sum;
    logic                s1_vld_d, s1_vld_q;
    logic [7:0]          s1_y_d, s1_y_q;
    logic [4:0]          s1_row_d, s1_row_q, s1_col_d, s1_col_q;
    logic [BLK_LOG2-1:0] s1_subh_d, s1_subh_q, s1_subv_d, s1_subv_q;

    always_comb begin
        h_off     = h_q - H_LO;
        v_off     = v_q - V_LO;
        luma_sum  = {2'b00, data_i[23:16]} + {1'b0, data_i[15:8], 1'b0} + {2'b00, data_i[7:0]};
        s1_y_d    = 8'(luma_sum >> 2);
        s1_vld_d  = data_valid_i && (h_q >= H_LO) && (h_q < H_HI) && (v_q >= V_LO) && (v_q < V_HI);
        s1_col_d  = 5'(h_off >> BLK_LOG2);
        s1_row_d  = 5'(v_off >> BLK_LOG2);
        s1_subh_d = h_off[BLK_LOG2-1:0];
        s1_subv_d = v_off[BLK_LOG2-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q       <= '0;
            v_q       <= '0;
            s1_vld_q  <= 1'b0;
            s1_y_q    <= '0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
            s1_subh_q <= '0;
            s1_subv_q <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            s1_vld_q  <= s1_vld_d;
            s1_y_q    <= s1_y_d;
            s1_row_q  <= s1_row_d;
            s1_col_q  <= s1_col_d;
            s1_subh_q <= s1_subh_d;
            s1_subv_q <= s1_subv_d;
        end
    end

    // Stage 2: one accumulator per output column, reused for every block row.
    logic [ACC_W-1:0] acc_q [D_DIM];
    logic [ACC_W-1:0] acc_sum;
    logic             blk_first, blk_last;
    logic [7:0]       avg, wr_data_d, wr_data_q;
    logic [9:0]       wr_addr_d, wr_addr_q;
    logic             wr_en_q, wr_last_q, frame_done_q, bank_q;

    always_comb begin
        blk_first = (s1_subh_q == '0) && (s1_subv_q == '0);
        blk_last  = (&s1_subh_q) && (&s1_subv_q);
        acc_sum   = (blk_first ? '0 : acc_q[s1_col_q]) + {{(ACC_W-8){1'b0}}, s1_y_q};
        avg       = 8'(acc_sum >> (2 * BLK_LOG2));
`ifdef DOWNSCALER_INVERT_EN
        wr_data_d = 8'hFF - avg;
`else
        wr_data_d = avg;
`endif
        wr_addr_d = 10'(s1_row_q) * 10'(D_DIM) + 10'(s1_col_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D_DIM; i++) acc_q[i] <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            bank_q       <= 1'b0;
        end else begin
            if (s1_vld_q) acc_q[s1_col_q] <= acc_sum;
            wr_en_q      <= s1_vld_q && blk_last;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_last_q    <= wr_en_q && (wr_addr_q == ADDR_LAST);
            frame_done_q <= wr_last_q;
            bank_q       <= bank_q ^ wr_last_q;
        end
    end

    logic [7:0] mem_q [2][N_PIX];
    logic [7:0] rd_data_q;

    // NOTE: the image RAM has no reset so it maps onto block RAM; only its read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en_q) mem_q[bank_q][wr_addr_q] <= wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset)                      rd_data_q <= '0;
        else if (rd_addr_i < ADDR_END)  rd_data_q <= mem_q[~bank_q][rd_addr_i];
        else                            rd_data_q <= '0;
    end

    assign rd_data_o    = rd_data_q;
    assign frame_done_o = frame_done_q;
    assign rd_bank_o    = ~bank_q;

endmodule

// File: tb/tb_mnist_downscaler.sv
// Bench for mnist_downscaler on a reduced raster (64x62, 2x2 blocks, 28x28 image) so whole
// frames stay short; expected images come from per-block sums of the generated pixels.
module tb_mnist_downscaler;

    localparam int H_RES    = 64;
    localparam int V_RES    = 62;
    localparam int D_DIM    = 28;
    localparam int BLK_LOG2 = 1;
    localparam int ROI_H    = 4;
    localparam int ROI_V    = 3;
    localparam int EDGE     = D_DIM << BLK_LOG2;
    localparam int N_PIX    = D_DIM * D_DIM;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_valid_i;
    logic [23:0] data_i;
    logic [9:0]  rd_addr_i;
    logic [7:0]  rd_data_o;
    logic        frame_done_o;
    logic        rd_bank_o;

    always #5 clk = ~clk;

    mnist_downscaler #(
        .H_RES(H_RES), .V_RES(V_RES), .D_DIM(D_DIM), .BLK_LOG2(BLK_LOG2),
        .ROI_H_START(ROI_H), .ROI_V_START(ROI_V)
    ) dut (
        .clk(clk), .reset(reset), .data_valid_i(data_valid_i), .data_i(data_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .frame_done_o(frame_done_o),
        .rd_bank_o(rd_bank_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int         pulses = 0;
    int         pulse_cyc = -1;
    logic [7:0] rd_at_pulse = '0;
    logic [7:0] rd_after = '0;
    bit         grab_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_done_o === 1'b1) begin
            pulses      <= pulses + 1;
            pulse_cyc   <= cyc;
            rd_at_pulse <= rd_data_o;
            grab_next   <= 1'b1;
        end else if (grab_next) begin
            rd_after  <= rd_data_o;
            grab_next <= 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] inv(input logic [7:0] b);
`ifdef DOWNSCALER_INVERT_EN
        return 8'hFF - b;
`else
        return b;
`endif
    endfunction

    function automatic bit in_roi(input int h, input int v);
        return (h >= ROI_H) && (h < ROI_H + EDGE) && (v >= ROI_V) && (v < ROI_V + EDGE);
    endfunction

    // Patterns: 0 uniform gray, 1 white outside / black inside, 2 block gradient, 3 random.
    function automatic logic [23:0] pix(input int pat, input int val, input int h, input int v);
        int g;
        case (pat)
            0: return {3{val[7:0]}};
            1: return in_roi(h, v) ? 24'h000000 : 24'hFFFFFF;
            2: begin
                if (!in_roi(h, v)) return 24'($urandom);
                g = ((v - ROI_V) >> BLK_LOG2) * 8 + ((h - ROI_H) >> BLK_LOG2);
                return {3{g[7:0]}};
            end
            default: return 24'($urandom);
        endcase
    endfunction

    longint     blk [D_DIM][D_DIM];
    logic [7:0] exp_img [N_PIX];
    logic [7:0] got_first, got_last;
    int         last_acc = -1;

    // gap: 0 none, 1 every third cycle idle, 2 random idles. stop_v >= 0 aborts at that line.
    task automatic run_frame(input int pat, input int val, input int gap, input int stop_v);
        int h = 0;
        int v = 0;
        int k = 0;
        int y;
        bit is_last;
        logic [23:0] px;
        for (int r = 0; r < D_DIM; r++)
            for (int c = 0; c < D_DIM; c++) blk[r][c] = 0;
        while (v < V_RES && v != stop_v) begin
            is_last = 1'b0;
            if ((gap == 1 && k % 3 == 2) || (gap == 2 && $urandom_range(0, 3) == 0)) begin
                data_valid_i = 1'b0;
                data_i       = 24'($urandom);
            end else begin
                px = pix(pat, val, h, v);
                data_valid_i = 1'b1;
                data_i       = px;
                if (in_roi(h, v)) begin
                    y = (int'(px[23:16]) + 2 * int'(px[15:8]) + int'(px[7:0])) / 4;
                    blk[(v - ROI_V) >> BLK_LOG2][(h - ROI_H) >> BLK_LOG2] += y;
                end
                is_last = (h == ROI_H + EDGE - 1) && (v == ROI_V + EDGE - 1);
                h++;
                if (h == H_RES) begin
                    h = 0;
                    v++;
                end
            end
            k++;
            @(posedge clk);
            #1;
            if (is_last) last_acc = cyc;
        end
        data_valid_i = 1'b0;
        for (int r = 0; r < D_DIM; r++)
            for (int c = 0; c < D_DIM; c++)
                exp_img[r * D_DIM + c] = inv(8'(blk[r][c] >> (2 * BLK_LOG2)));
    endtask

    task automatic read_image(input string name);
        int nerr = 0;
        int first = -1;
        rd_addr_i = 10'd0;
        for (int a = 0; a < N_PIX; a++) begin
            @(posedge clk);
            #1;
            rd_addr_i = (a + 1 < N_PIX) ? 10'(a + 1) : 10'd0;
            @(negedge clk);
            if (a == 0) got_first = rd_data_o;
            if (a == N_PIX - 1) got_last = rd_data_o;
            if (rd_data_o !== exp_img[a]) begin
                nerr++;
                if (first < 0) first = a;
            end
        end
        check({name, "_img_errors"}, nerr, 0);
        if (nerr > 0) $display("  %s first differing byte at address %0d", name, first);
    endtask

    task automatic finish_frame(input string name, input int p0, input bit exp_bank);
        repeat (6) @(posedge clk);
        #1;
        check({name, "_pulse_count"}, pulses - p0, 1);
        check({name, "_done_cycle"}, pulse_cyc, last_acc + 3);
        check({name, "_rd_bank"}, rd_bank_o, exp_bank);
    endtask

    typedef struct {
        string name;
        int    pat;
        int    val;
        int    gap;
        int    exp_first;
        int    exp_last;
        bit    exp_bank;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int p0;
        tbl[0] = '{"uniform80",  0, 8'h80, 0, 8'h80, 8'h80, 1'b0};
        tbl[1] = '{"roi_edges",  1, 0,     0, 8'h00, 8'h00, 1'b1};
        tbl[2] = '{"gradient",   2, 0,     1, 0,     243,   1'b0};
        tbl[3] = '{"random",     3, 0,     2, -1,    -1,    1'b1};
        tbl[4] = '{"uniform40",  0, 8'h40, 2, 8'h40, 8'h40, 1'b0};

        reset        = 1'b1;
        data_valid_i = 1'b0;
        data_i       = '0;
        rd_addr_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd_data", rd_data_o, 8'h00);
        check("reset_frame_done", frame_done_o, 1'b0);
        check("reset_rd_bank", rd_bank_o, 1'b1);
        reset     = 1'b0;
        rd_addr_i = 10'd800;
        @(posedge clk);
        @(negedge clk);
        check("addr800_after_reset", rd_data_o, 8'h00);

        for (int i = 0; i < 5; i++) begin
            p0 = pulses;
            run_frame(tbl[i].pat, tbl[i].val, tbl[i].gap, -1);
            finish_frame(tbl[i].name, p0, tbl[i].exp_bank);
            read_image(tbl[i].name);
            if (tbl[i].exp_first >= 0) begin
                check({tbl[i].name, "_byte0"}, got_first, inv(8'(tbl[i].exp_first)));
                check({tbl[i].name, "_byte783"}, got_last, inv(8'(tbl[i].exp_last)));
            end
        end

        // Second image while reading a fixed address: old bank through the pulse cycle.
        rd_addr_i = 10'd5;
        p0 = pulses;
        run_frame(0, 8'hC0, 0, -1);
        finish_frame("uniformC0", p0, 1'b1);
        check("swap_read_at_pulse", rd_at_pulse, inv(8'h40));
        check("swap_read_after", rd_after, inv(8'hC0));
        read_image("uniformC0");
        rd_addr_i = 10'd800;
        @(posedge clk);
        @(negedge clk);
        check("addr800_loaded", rd_data_o, 8'h00);

        // Reset in the middle of the ROI, then a complete frame.
        p0 = pulses;
        run_frame(0, 8'h20, 0, ROI_V + 16);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset_rd_bank", rd_bank_o, 1'b1);
        check("midreset_rd_data", rd_data_o, 8'h00);
        check("midreset_pulses", pulses - p0, 0);
        reset = 1'b0;
        run_frame(0, 8'h20, 0, -1);
        finish_frame("after_reset", p0, 1'b0);
        read_image("after_reset");
        check("after_reset_byte0", got_first, inv(8'h20));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
